// File: rtl/idli_sqi_ctrl_m.sv
// idli_sqi_ctrl_m: single-word SQI memory controller (cmd/addr/dummy/data sequencing, SCK, CS, SIO direction).
// Define IDLI_SQI_CTRL_BURST_EN to hold CS open after a transfer so a sequential request skips cmd/addr.
module idli_sqi_ctrl_m (
    input  logic        i_sqc_gck,
    input  logic        i_sqc_rst,
    input  logic        i_sqc_req_vld,
    output logic        o_sqc_req_rdy,
    input  logic        i_sqc_req_wr,
    input  logic [15:0] i_sqc_req_addr,
    input  logic [15:0] i_sqc_req_data,
    output logic        o_sqc_rsp_vld,
    output logic [15:0] o_sqc_rsp_data,
    output logic        o_sqc_sck,
    output logic        o_sqc_cs,
    output logic [3:0]  o_sqc_sio,
    output logic        o_sqc_sio_oe,
    input  logic [3:0]  i_sqc_sio
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_DUMMY = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
`ifdef IDLI_SQI_CTRL_BURST_EN
    localparam logic [2:0] ST_HOLD  = 3'd6;
`endif

    logic [2:0]  state_q, state_d;
    logic [2:0]  cnt_q;
    logic        ph_q;
    logic        wr_q;
    logic [15:0] addr_q, data_q, sh_q, rsp_q;
    logic        rsp_vld_q;
    logic        acc, last, in_txn;
    logic [1:0]  idx;
    logic [15:0] word;

    assign in_txn = state_q inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA};
    assign last   = ph_q && cnt_q == ((state_q == ST_ADDR || state_q == ST_DATA) ? 3'd3 : 3'd1);
    assign acc    = i_sqc_req_vld && o_sqc_req_rdy;

`ifdef IDLI_SQI_CTRL_BURST_EN
    logic pend_q;
    logic seq;
    // 0xFFFF -> 0x0000 is deliberately not treated as sequential
    assign seq           = i_sqc_req_wr == wr_q && addr_q != 16'hFFFF && i_sqc_req_addr == addr_q + 16'd1;
    assign o_sqc_req_rdy = state_q == ST_IDLE || state_q == ST_HOLD;
    assign o_sqc_cs      = in_txn || state_q == ST_HOLD;
`else
    assign o_sqc_req_rdy = state_q == ST_IDLE;
    assign o_sqc_cs      = in_txn;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = acc ? ST_CMD : ST_IDLE;
            ST_CMD:   state_d = last ? ST_ADDR : ST_CMD;
            ST_ADDR:  state_d = last ? (wr_q ? ST_DATA : ST_DUMMY) : ST_ADDR;
            ST_DUMMY: state_d = last ? ST_DATA : ST_DUMMY;
`ifdef IDLI_SQI_CTRL_BURST_EN
            ST_DATA:  state_d = last ? ST_HOLD : ST_DATA;
            ST_DONE:  state_d = pend_q ? ST_CMD : ST_IDLE;
            ST_HOLD:  state_d = acc ? (seq ? ST_DATA : ST_DONE) : ST_HOLD;
`else
            ST_DATA:  state_d = last ? ST_DONE : ST_DATA;
            ST_DONE:  state_d = ST_IDLE;
`endif
            default:  state_d = ST_IDLE;
        endcase
    end

    // Every field is sent MSB slice first; the command byte sits in the top half of the word
    assign idx            = 2'd3 - cnt_q[1:0];
    assign word           = state_q == ST_CMD ? {6'b0, 1'b1, ~wr_q, 8'h00} : state_q == ST_ADDR ? addr_q : data_q;
    assign o_sqc_sio_oe   = state_q == ST_CMD || state_q == ST_ADDR || (state_q == ST_DATA && wr_q);
    assign o_sqc_sio      = o_sqc_sio_oe ? word[{idx, 2'b00} +: 4] : 4'h0;
    assign o_sqc_sck      = ph_q;
    assign o_sqc_rsp_vld  = rsp_vld_q;
    assign o_sqc_rsp_data = (rsp_vld_q && wr_q) ? 16'h0000 : rsp_q;

    always_ff @(posedge i_sqc_gck) begin
        if (i_sqc_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            ph_q      <= 1'b0;
            rsp_vld_q <= 1'b0;
            rsp_q     <= 16'h0000;
`ifdef IDLI_SQI_CTRL_BURST_EN
            pend_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ph_q      <= in_txn && !ph_q;
            cnt_q     <= last ? 3'd0 : (in_txn && ph_q) ? cnt_q + 3'd1 : cnt_q;
            rsp_vld_q <= state_q == ST_DATA && last;
            if (acc) begin
                wr_q   <= i_sqc_req_wr;
                addr_q <= i_sqc_req_addr;
                data_q <= i_sqc_req_data;
            end
            if (state_q == ST_DATA && ph_q)
                sh_q <= {sh_q[11:0], i_sqc_sio};
            if (state_q == ST_DATA && last && !wr_q)
                rsp_q <= {sh_q[11:0], i_sqc_sio};
`ifdef IDLI_SQI_CTRL_BURST_EN
            pend_q    <= state_q == ST_HOLD && acc && !seq;
`endif
        end
    end
endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// tb_idli_sqi_ctrl_m: scoreboard bench for idli_sqi_ctrl_m with a behavioural SQI memory model.
// Burst checks are compiled only when IDLI_SQI_CTRL_BURST_EN is defined.
module tb_idli_sqi_ctrl_m;
    logic        clk = 1'b0, rst = 1'b1, vld = 1'b0, wr = 1'b0;
    logic [15:0] addr = 16'h0, wdata = 16'h0;
    logic        rdy, rsp_vld, sck, cs, oe;
    logic [15:0] rsp_data;
    logic [3:0]  sio, sio_in = 4'h0;

    typedef struct {
        logic [15:0] d;
        int          cyc;
        int          cs_n;
        int          oe_n;
        int          lo;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mem [logic [15:0]];
    logic [3:0]  slog[$];
    int          total = 0, bad = 0, cyc = 0, hl = 0;
    int          sc = 0, cs_n = 0, oe_n = 0, cs_lo = 0;
    logic [7:0]  m_cmd = 8'h0;
    logic [15:0] m_addr = 16'h0, m_wd = 16'h0;

    idli_sqi_ctrl_m dut (
        .i_sqc_gck      (clk),
        .i_sqc_rst      (rst),
        .i_sqc_req_vld  (vld),
        .o_sqc_req_rdy  (rdy),
        .i_sqc_req_wr   (wr),
        .i_sqc_req_addr (addr),
        .i_sqc_req_data (wdata),
        .o_sqc_rsp_vld  (rsp_vld),
        .o_sqc_rsp_data (rsp_data),
        .o_sqc_sck      (sck),
        .o_sqc_cs       (cs),
        .o_sqc_sio      (sio),
        .o_sqc_sio_oe   (oe),
        .i_sqc_sio      (sio_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    // Monitor first (counters snapshot excludes the response cycle), then the memory model
    always @(negedge clk) begin : mon_model
        exp_t        e;
        int          d;
        logic [15:0] w;
        if (rsp_vld) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: rsp_vld=1 data=0x%0h, none required", rsp_data);
            end else begin
                e = sb.pop_front();
                chk("rsp_data", rsp_data, e.d);
                chk("rsp_cycle", cyc, e.cyc);
                chk("cs_high_cycles", cs_n, e.cs_n);
                chk("oe_cycles", oe_n, e.oe_n);
                chk("cs_low_cycles", cs_lo, e.lo);
            end
        end
        if (!oe) chk("sio_zero_when_not_driven", sio, 0);
        cs_n  = cs_n + (cs ? 1 : 0);
        oe_n  = oe_n + (oe ? 1 : 0);
        cs_lo = cs_lo + (cs ? 0 : 1);
        if (!cs) begin
            sc     = 0;
            sio_in = 4'h0;
        end else if (!sck) begin
            if (m_cmd == 8'h03 && sc >= 8) begin
                d      = sc - 8;
                w      = mem_rd(16'(m_addr + d / 4));
                sio_in = w[4 * (3 - d % 4) +: 4];
            end else begin
                sio_in = 4'h0;
            end
        end else begin
            slog.push_back(sio);
            if (sc < 2) m_cmd = {m_cmd[3:0], sio};
            else if (sc < 6) m_addr = {m_addr[11:0], sio};
            else if (m_cmd == 8'h02) begin
                d    = sc - 6;
                m_wd = {m_wd[11:0], sio};
                if (d % 4 == 3) mem[16'(m_addr + d / 4)] = m_wd;
            end
            sc++;
        end
    end

    task automatic send(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [15:0] ed,
                        input int lat, input int csn, input int oen, input int lo, input bit push, output int acc);
        int t = 0;
        vld = 1'b1; wr = w; addr = a; wdata = d;
        while (!rdy && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("accept_within_budget", rdy, 1);
        acc = cyc;
        if (push) sb.push_back('{ed, cyc + lat, csn, oen, lo});
        @(posedge clk);
        #1;
        cs_n = 0; oe_n = 0; cs_lo = 0;
        slog.delete();
        @(negedge clk);
        vld = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("rsp_within_budget", sb.size(), 0);
        @(negedge clk);
`ifdef IDLI_SQI_CTRL_BURST_EN
        hl = 1;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int         acc1, acc2;
        logic [3:0] exp_rd[8];
        logic [3:0] exp_wr[10];
        exp_rd = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
        exp_wr = '{4'h0, 4'h2, 4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'h5, 4'hC, 4'h3};
        mem[16'h0010] = 16'hBEEF;
        mem[16'h0020] = 16'h1111;
        mem[16'h0021] = 16'h2222;
        mem[16'h0030] = 16'h3333;
        mem[16'hFFFF] = 16'hF0F0;
        mem[16'h0000] = 16'h0A0A;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_cs", cs, 0);
        chk("reset_sck", sck, 0);
        chk("reset_sio", sio, 0);
        chk("reset_oe", oe, 0);
        chk("reset_rsp_vld", rsp_vld, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rdy", rdy, 1);

        send(1'b0, 16'h0010, 16'h0, 16'hBEEF, 25, 24, 12, 0, 1'b1, acc1);
        wait_done();
        chk("read_slice_count", slog.size(), 12);
        for (int i = 0; i < 8; i++)
            chk($sformatf("read_slice%0d", i), (i < slog.size()) ? 32'(slog[i]) : 32'hFFFF, exp_rd[i]);

        send(1'b1, 16'h1234, 16'hA5C3, 16'h0000, 21 + hl, 20, 20, hl, 1'b1, acc1);
        wait_done();
        chk("write_slice_count", slog.size(), 10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("write_slice%0d", i), (i < slog.size()) ? 32'(slog[i]) : 32'hFFFF, exp_wr[i]);

        send(1'b0, 16'h1234, 16'h0, 16'hA5C3, 25 + hl, 24, 12, hl, 1'b1, acc1);
        wait_done();

        send(1'b0, 16'h0010, 16'h0, 16'hBEEF, 25 + hl, 24, 12, hl, 1'b1, acc1);
        send(1'b0, 16'h1234, 16'h0, 16'hA5C3, 25 + hl, 24, 12, hl, 1'b1, acc2);
        chk("b2b_accept_gap", acc2 - acc1, 26);
        wait_done();

        send(1'b0, 16'h0010, 16'h0, 16'h0, 0, 0, 0, 0, 1'b0, acc1);
        repeat (8) @(negedge clk);
        chk("addr_slice3_cs", cs, 1);
        chk("addr_slice3_oe", oe, 1);
        rst = 1'b1; vld = 1'b1; wr = 1'b0; addr = 16'h0030;
        @(negedge clk);
        chk("mid_rst_cs", cs, 0);
        chk("mid_rst_oe", oe, 0);
        chk("mid_rst_sck", sck, 0);
        chk("mid_rst_rdy", rdy, 1);
        chk("mid_rst_rsp_vld", rsp_vld, 0);
        @(negedge clk);
        rst = 1'b0; vld = 1'b0;
        hl = 0;
        @(negedge clk);
        chk("no_accept_in_rst_cs", cs, 0);
        chk("no_accept_in_rst_rdy", rdy, 1);
        repeat (3) @(negedge clk);
        send(1'b0, 16'h0010, 16'h0, 16'hBEEF, 25, 24, 12, 0, 1'b1, acc1);
        wait_done();

`ifdef IDLI_SQI_CTRL_BURST_EN
        send(1'b0, 16'h0020, 16'h0, 16'h1111, 26, 24, 12, 1, 1'b1, acc1);
        wait_done();
        chk("hold_cs_open", cs, 1);
        send(1'b0, 16'h0021, 16'h0, 16'h2222, 9, 8, 0, 0, 1'b1, acc1);
        wait_done();
        chk("burst_seq_slices", slog.size(), 4);
        send(1'b0, 16'h0030, 16'h0, 16'h3333, 26, 24, 12, 1, 1'b1, acc1);
        wait_done();
        chk("burst_break_slices", slog.size(), 12);
        send(1'b0, 16'hFFFF, 16'h0, 16'hF0F0, 26, 24, 12, 1, 1'b1, acc1);
        wait_done();
        send(1'b0, 16'h0000, 16'h0, 16'h0A0A, 26, 24, 12, 1, 1'b1, acc1);
        wait_done();
        chk("no_wrap_full_slices", slog.size(), 12);
`endif

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
